// File: rtl/fifo_rd_stream_if.sv
// Valid/ready output stream carried from the FIFO read consumer to its sink.
interface fifo_rd_stream_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;

   modport master (output m_valid, output m_data, input m_ready);
   modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the async FIFO: issues rd_en from empty, absorbs the
// one-cycle read latency and re-presents words through a 2-entry skid buffer.
//
// state   | meaning
// S_EMPTY | no word buffered, m_valid low
// S_ONE   | one word buffered in r_buf0
// S_TWO   | two words buffered, r_buf0 is the head
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_rd,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   fifo_rd_stream_if.master      m_if,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic                  idle
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

   // ADDR_WIDTH only documents the FIFO this block pairs with.
   if (ADDR_WIDTH < 1) begin : g_addr_width_invalid
   end

   state_t                r_state;
   state_t                w_state_next;
   logic                  r_inflight;
   logic [DATA_WIDTH-1:0] r_buf0;
   logic [DATA_WIDTH-1:0] r_buf1;
   logic [DATA_WIDTH-1:0] w_buf0_next;
   logic [DATA_WIDTH-1:0] w_buf1_next;
   logic [CNT_WIDTH-1:0]  r_count;
   logic [1:0]            w_occ;
   logic [1:0]            w_slot;
   logic [2:0]            w_level;
   logic                  w_pop;
   logic                  w_capture;

   always_comb begin
      w_occ = 2'd0;
      case (r_state)
         S_ONE:   w_occ = 2'd1;
         S_TWO:   w_occ = 2'd2;
         default: w_occ = 2'd0;
      endcase
   end

   assign w_pop     = (r_state != S_EMPTY) && m_if.m_ready;
   assign w_capture = r_inflight;

   // Occupancy after this edge; a new read is only issued if it will fit.
   assign w_level    = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign fifo_rd_en = enable && !fifo_empty && (w_level < 3'd2);

   always_ff @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_EMPTY: begin
            if (w_capture) w_state_next = S_ONE;
         end
         S_ONE: begin
            if (w_capture && !w_pop)      w_state_next = S_TWO;
            else if (!w_capture && w_pop) w_state_next = S_EMPTY;
         end
         S_TWO: begin
            if (!w_capture && w_pop) w_state_next = S_ONE;
         end
         default: w_state_next = S_EMPTY;
      endcase
   end

   // A pop shifts the tail to the head, so a same-cycle capture lands one slot lower.
   assign w_slot = w_occ - {1'b0, w_pop};

   always_comb begin
      w_buf0_next = r_buf0;
      w_buf1_next = r_buf1;
      if (w_pop && (r_state == S_TWO)) begin
         w_buf0_next = r_buf1;
      end
      if (w_capture) begin
         if (w_slot == 2'd0) w_buf0_next = fifo_data;
         else                w_buf1_next = fifo_data;
      end
   end

   always_ff @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight <= 1'b0;
         r_buf0     <= '0;
         r_buf1     <= '0;
         r_count    <= '0;
      end else begin
         r_inflight <= fifo_rd_en;
         r_buf0     <= w_buf0_next;
         r_buf1     <= w_buf1_next;
         if (w_pop) begin
            r_count <= r_count + CNT_ONE;
         end
      end
   end

   assign m_if.m_valid = (r_state != S_EMPTY);
   assign m_if.m_data  = r_buf0;
   assign rd_count     = r_count;
   assign idle         = (r_state == S_EMPTY) && !r_inflight;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO and reference consumer drive two
// instances (16-bit and 4-bit counters) through directed and random traffic.
module tb_fifo_rd_stream;

   logic        clk_rd = 1'b0;
   logic        rst_n  = 1'b1;
   logic        enable;
   logic        m_ready;
   logic        fifo_empty;
   logic [7:0]  fifo_data;
   logic        rd_en_a, rd_en_b;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;
   logic        idle_a, idle_b;

   int nchk = 0;
   int nerr = 0;

   always #5 clk_rd = ~clk_rd;

   fifo_rd_stream_if #(.DATA_WIDTH(8)) s_a ();
   fifo_rd_stream_if #(.DATA_WIDTH(8)) s_b ();
   assign s_a.m_ready = m_ready;
   assign s_b.m_ready = m_ready;

   fifo_rd_stream #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CNT_WIDTH(16)) u_dut_a (
      .clk_rd(clk_rd), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_data(fifo_data), .fifo_rd_en(rd_en_a), .m_if(s_a),
      .rd_count(cnt_a), .idle(idle_a));

   fifo_rd_stream #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CNT_WIDTH(4)) u_dut_b (
      .clk_rd(clk_rd), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_data(fifo_data), .fifo_rd_en(rd_en_b), .m_if(s_b),
      .rd_count(cnt_b), .idle(idle_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: FIFO contents, words already delivered by the FIFO but not yet
   // accepted downstream, and whether a read was issued last cycle.
   logic [7:0] fq[$];
   logic [7:0] pend[$];
   logic [7:0] mbuf[$];
   bit         m_inflight;
   logic [7:0] m_word;
   int         mcnt;
   bit         s_exp_rd, s_exp_pop;

   always @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) begin
         fq.delete();
         pend.delete();
         mbuf.delete();
         m_inflight = 1'b0;
         m_word     = 8'h00;
         mcnt       = 0;
         fifo_data  <= 8'h00;
         fifo_empty <= 1'b1;
      end else begin
         if (s_exp_pop) begin
            void'(mbuf.pop_front());
            mcnt++;
         end
         if (m_inflight) mbuf.push_back(m_word);
         m_inflight = s_exp_rd;
         if (s_exp_rd && fq.size() > 0) begin
            m_word = fq.pop_front();
            fifo_data <= m_word;
         end
         while (pend.size() > 0) fq.push_back(pend.pop_front());
         fifo_empty <= (fq.size() == 0);
      end
   end

   always @(negedge clk_rd) begin
      if (!rst_n) begin
         s_exp_rd  = 1'b0;
         s_exp_pop = 1'b0;
      end else begin
         bit ev, ep, er, ei;
         ev = (mbuf.size() != 0);
         ep = ev && m_ready;
         er = enable && !fifo_empty && ((int'(mbuf.size()) + int'(m_inflight) - int'(ep)) < 2);
         ei = !ev && !m_inflight;
         chk("mdl_rd_en_a", rd_en_a, er);
         chk("mdl_rd_en_b", rd_en_b, er);
         chk("mdl_valid_a", s_a.m_valid, ev);
         chk("mdl_valid_b", s_b.m_valid, ev);
         chk("mdl_idle_a", idle_a, ei);
         chk("mdl_idle_b", idle_b, ei);
         chk("mdl_count_a", cnt_a, mcnt & 32'hFFFF);
         chk("mdl_count_b", cnt_b, mcnt & 32'hF);
         if (ev) begin
            chk("mdl_data_a", s_a.m_data, mbuf[0]);
            chk("mdl_data_b", s_b.m_data, mbuf[0]);
         end
         s_exp_rd  = er;
         s_exp_pop = ep;
      end
   end

   task automatic tick;
      @(posedge clk_rd);
      #1;
   endtask

   task automatic do_reset;
      enable  = 1'b0;
      m_ready = 1'b0;
      @(posedge clk_rd);
      #1 rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit         en;
      bit         rdy;
      bit         exp_rd;
      bit         exp_v;
      logic [7:0] exp_d;
      bit         exp_idle;
      int         exp_cnt;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [7:0] got[$];
      int run_rd, max_rd, run_v, max_v, nrd, npush;
      bit seen15, seen16, seen17;

      vecs[0] = '{1, 1, 1, 0, 8'h00, 1, 0};
      vecs[1] = '{1, 1, 0, 0, 8'h00, 0, 0};
      vecs[2] = '{1, 1, 0, 1, 8'hA5, 0, 0};
      vecs[3] = '{1, 1, 0, 0, 8'h00, 1, 1};
      vecs[4] = '{1, 1, 0, 0, 8'h00, 1, 1};

      enable  = 1'b0;
      m_ready = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk_rd);
      @(negedge clk_rd);
      chk("rst_rd_en", rd_en_a, 0);
      chk("rst_valid", s_a.m_valid, 0);
      chk("rst_data", s_a.m_data, 0);
      chk("rst_count", cnt_a, 0);
      chk("rst_idle", idle_a, 1);
      @(posedge clk_rd);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_rd);
         chk("post_rst_rd_en", rd_en_a, 0);
         chk("post_rst_valid", s_a.m_valid, 0);
         chk("post_rst_data", s_a.m_data, 0);
         chk("post_rst_count", cnt_a, 0);
         chk("post_rst_idle", idle_a, 1);
      end

      // Single word through the table.
      do_reset();
      enable  = 1'b1;
      m_ready = 1'b1;
      pend.push_back(8'hA5);
      tick();
      for (int i = 0; i < 5; i++) begin
         enable  = vecs[i].en;
         m_ready = vecs[i].rdy;
         @(negedge clk_rd);
         chk("vec_rd_en", rd_en_a, vecs[i].exp_rd);
         chk("vec_valid", s_a.m_valid, vecs[i].exp_v);
         if (vecs[i].exp_v) chk("vec_data", s_a.m_data, vecs[i].exp_d);
         chk("vec_idle", idle_a, vecs[i].exp_idle);
         chk("vec_count", cnt_a, vecs[i].exp_cnt);
         tick();
      end

      // Streaming 16 words.
      do_reset();
      for (int i = 0; i < 16; i++) pend.push_back(8'(i));
      tick();
      enable  = 1'b1;
      m_ready = 1'b1;
      got.delete();
      run_rd = 0; max_rd = 0; run_v = 0; max_v = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk_rd);
         run_rd = rd_en_a ? run_rd + 1 : 0;
         run_v  = s_a.m_valid ? run_v + 1 : 0;
         if (run_rd > max_rd) max_rd = run_rd;
         if (run_v > max_v) max_v = run_v;
         if (s_a.m_valid && m_ready) got.push_back(s_a.m_data);
         tick();
      end
      chk("stream_rd_run", max_rd, 16);
      chk("stream_valid_run", max_v, 16);
      chk("stream_beats", got.size(), 16);
      for (int i = 0; i < 16 && i < got.size(); i++) chk("stream_order", got[i], i);
      @(negedge clk_rd);
      chk("stream_count_a", cnt_a, 16);
      chk("stream_count_b", cnt_b, 0);

      // Backpressure.
      do_reset();
      for (int i = 0; i < 5; i++) pend.push_back(8'(8'h10 + i));
      tick();
      enable = 1'b1;
      nrd = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk_rd);
         nrd += int'(rd_en_a);
         tick();
      end
      @(negedge clk_rd);
      chk("bp_reads", nrd, 2);
      chk("bp_valid", s_a.m_valid, 1);
      chk("bp_head", s_a.m_data, 8'h10);
      tick();
      got.delete();
      for (int k = 0; k < 60 && got.size() < 5; k++) begin
         m_ready = k[0];
         @(negedge clk_rd);
         if (s_a.m_valid && m_ready) got.push_back(s_a.m_data);
         tick();
      end
      chk("bp_beats", got.size(), 5);
      for (int i = 0; i < 5 && i < got.size(); i++) chk("bp_order", got[i], 8'h10 + i);
      @(negedge clk_rd);
      chk("bp_count", cnt_a, 5);

      // Enable drop after the third read, then reset mid-stream.
      do_reset();
      for (int i = 0; i < 8; i++) pend.push_back(8'(8'h20 + i));
      tick();
      enable  = 1'b1;
      m_ready = 1'b1;
      nrd = 0;
      for (int c = 0; c < 20 && nrd < 3; c++) begin
         @(negedge clk_rd);
         nrd += int'(rd_en_a);
         tick();
      end
      enable = 1'b0;
      nrd = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_rd);
         nrd += int'(rd_en_a);
         tick();
      end
      @(negedge clk_rd);
      chk("endrop_extra_reads", nrd, 0);
      chk("endrop_count", cnt_a, 3);
      chk("endrop_idle", idle_a, 1);
      tick();
      enable = 1'b1;
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid_a", s_a.m_valid, 0);
      chk("midrst_valid_b", s_b.m_valid, 0);
      chk("midrst_count_a", cnt_a, 0);
      chk("midrst_count_b", cnt_b, 0);
      chk("midrst_idle", idle_a, 1);
      tick();
      rst_n = 1'b1;

      // Counter wrap on the 4-bit instance.
      do_reset();
      for (int i = 0; i < 17; i++) pend.push_back(8'(8'h40 + i));
      tick();
      enable  = 1'b1;
      m_ready = 1'b1;
      seen15 = 0; seen16 = 0; seen17 = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk_rd);
         if (cnt_a == 16'd15 && !seen15) begin chk("wrap_15", cnt_b, 15); seen15 = 1; end
         if (cnt_a == 16'd16 && !seen16) begin chk("wrap_16", cnt_b, 0);  seen16 = 1; end
         if (cnt_a == 16'd17 && !seen17) begin chk("wrap_17", cnt_b, 1);  seen17 = 1; end
         tick();
      end
      chk("wrap_seen", int'(seen15) + int'(seen16) + int'(seen17), 3);

      // Random traffic against the reference.
      do_reset();
      npush = 0;
      for (int c = 0; c < 1500; c++) begin
         enable  = ($urandom_range(0, 7) != 0);
         m_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 1) == 1 && (fq.size() + pend.size()) < 16) begin
            pend.push_back(8'($urandom_range(0, 255)));
            npush++;
         end
         tick();
      end
      enable  = 1'b1;
      m_ready = 1'b1;
      repeat (40) tick();
      @(negedge clk_rd);
      chk("rand_count_a", cnt_a, npush & 32'hFFFF);
      chk("rand_count_b", cnt_b, npush & 32'hF);
      chk("rand_idle", idle_a, 1);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", nchk, nerr);
      $fatal(1, "watchdog");
   end

endmodule
